// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU share arbiter: FSM state encoding, ALUOp
// class constants and the control codes presented to the shared ALU.
// -----------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // ALUOp classes as produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // funct3 values that need special treatment in the mapping
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SHR    = 3'b101;

    // Shared ALU control codes
    localparam logic [3:0] CTRL_ADD = 4'd0;
    localparam logic [3:0] CTRL_SRL = 4'd6;
    localparam logic [3:0] CTRL_SUB = 4'd8;
    localparam logic [3:0] CTRL_SRA = 4'd9;

endpackage

// File: rtl/alu_share_arbiter_alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
// Combinational mapping from (aluop, funct7 bit, funct3) to the 4-bit control
// code of the shared ALU. Total over all inputs, never produces X.
//   aluop    in  2  op class
//   funct7   in  1  instruction bit 30
//   funct3   in  3  instruction funct3
//   alu_ctrl out 4  control code
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_share_arbiter_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic       funct7,
    input  logic [2:0] funct3,
    output logic [3:0] alu_ctrl
);

    // Decode op class and function fields into an ALU control code
    always_comb begin
        alu_ctrl = CTRL_ADD;
        case (aluop)
            ALUOP_ADD: alu_ctrl = CTRL_ADD;
            ALUOP_SUB: alu_ctrl = CTRL_SUB;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                if (funct3 == F3_ADDSUB) begin
                    // Bit 30 selects sub only for R-type; for I-type it is immediate data
                    alu_ctrl = ((aluop == ALUOP_RTYPE) && funct7) ? CTRL_SUB : CTRL_ADD;
                end else if (funct3 == F3_SHR) begin
                    alu_ctrl = funct7 ? CTRL_SRA : CTRL_SRL;
                end else begin
                    alu_ctrl = {1'b0, funct3};
                end
            end
            default: alu_ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters. An op is accepted in
// IDLE (round-robin on ties), executed for one cycle in EXEC, and its result
// is held in RESP until the consumer takes it.
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          requester N handshake (ready is combinational)
//   reqN_aluop/funct7/funct3  requester N op description
//   reqN_a, reqN_b            requester N operands
//   alu_ctrl, alu_a, alu_b    drive to the shared ALU (zero outside EXEC)
//   alu_result                combinational ALU result
//   resp_valid/id/result      registered response, resp_ready consumes it
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_aluop,
    input  logic              req0_funct7,
    input  logic [2:0]        req0_funct3,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_aluop,
    input  logic              req1_funct7,
    input  logic [2:0]        req1_funct3,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    input  logic              resp_ready
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              last_grant_r;
    logic              grant_id_r;
    logic              grant0_s;
    logic              grant1_s;
    logic [1:0]        op_aluop_r;
    logic              op_funct7_r;
    logic [2:0]        op_funct3_r;
    logic [DATA_W-1:0] op_a_r;
    logic [DATA_W-1:0] op_b_r;
    logic [3:0]        dec_ctrl_s;
    logic              resp_valid_r;
    logic              resp_id_r;
    logic [DATA_W-1:0] resp_result_r;

    alu_op_decode u_decode (
        .aluop    (op_aluop_r),
        .funct7   (op_funct7_r),
        .funct3   (op_funct3_r),
        .alu_ctrl (dec_ctrl_s)
    );

    // Arbitration and next-state logic; grants exist only in IDLE out of reset
    always_comb begin
        state_nxt_s = state_r;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst) begin
                    // On a tie, requester 0 wins when requester 1 was granted last
                    grant0_s = req0_valid && (!req1_valid || last_grant_r);
                    grant1_s = req1_valid && !(req0_valid && (!req1_valid || last_grant_r));
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
                if (grant0_s || grant1_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Shared ALU drive, only from the latched op and only during EXEC
    always_comb begin
        alu_ctrl = 4'd0;
        alu_a    = '0;
        alu_b    = '0;
        if (state_r == ST_EXEC) begin
            alu_ctrl = dec_ctrl_s;
            alu_a    = op_a_r;
            alu_b    = op_b_r;
        end else begin
            alu_ctrl = 4'd0;
            alu_a    = '0;
            alu_b    = '0;
        end
    end

    // State register and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            grant_id_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant0_s || grant1_s) begin
                last_grant_r <= grant1_s;
                grant_id_r   <= grant1_s;
            end
        end
    end

    // Latch the granted op; requester inputs are ignored after this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_aluop_r  <= 2'b00;
            op_funct7_r <= 1'b0;
            op_funct3_r <= 3'b000;
            op_a_r      <= '0;
            op_b_r      <= '0;
        end else if (grant0_s || grant1_s) begin
            op_aluop_r  <= grant1_s ? req1_aluop  : req0_aluop;
            op_funct7_r <= grant1_s ? req1_funct7 : req0_funct7;
            op_funct3_r <= grant1_s ? req1_funct3 : req0_funct3;
            op_a_r      <= grant1_s ? req1_a      : req0_a;
            op_b_r      <= grant1_s ? req1_b      : req0_b;
        end
    end

    // Response capture at the end of EXEC; held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_r  <= 1'b0;
            resp_id_r     <= 1'b0;
            resp_result_r <= '0;
        end else if (state_r == ST_EXEC) begin
            resp_valid_r  <= 1'b1;
            resp_id_r     <= grant_id_r;
            resp_result_r <= alu_result;
        end else if ((state_r == ST_RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
        end
    end

    assign resp_valid  = resp_valid_r;
    assign resp_id     = resp_id_r;
    assign resp_result = resp_result_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed and randomized checks of the ALU share arbiter against a
// behavioural model of arbitration, op decoding and a reference ALU.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              v  [2];
    logic [1:0]        op [2];
    logic              f7 [2];
    logic [2:0]        f3 [2];
    logic [DATA_W-1:0] a  [2];
    logic [DATA_W-1:0] b  [2];
    logic              req0_ready, req1_ready;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              resp_valid, resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_ready = 1'b0;

    int tests = 0;
    int fails = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    // Reference ALU; also serves as the shared ALU the arbiter drives
    function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] x, logic [31:0] y);
        case (c)
            4'd0: return x + y;
            4'd8: return x - y;
            4'd1: return x << y[4:0];
            4'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd3: return (x < y) ? 32'd1 : 32'd0;
            4'd4: return x ^ y;
            4'd6: return x >> y[4:0];
            4'd9: return 32'($signed(x) >>> y[4:0]);
            4'd7: return x & y;
            default: return x | y;
        endcase
    endfunction

    // Expected control code from op class / funct fields
    function automatic logic [3:0] model_ctrl(logic [1:0] aop, logic s7, logic [2:0] s3);
        if (aop == 2'b00) return 4'd0;
        if (aop == 2'b01) return 4'd8;
        if (s3 == 3'b000) return (aop == 2'b10 && s7) ? 4'd8 : 4'd0;
        if (s3 == 3'b101) return s7 ? 4'd9 : 4'd6;
        return {1'b0, s3};
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    alu_share_arbiter #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (v[0]),
        .req0_ready  (req0_ready),
        .req0_aluop  (op[0]),
        .req0_funct7 (f7[0]),
        .req0_funct3 (f3[0]),
        .req0_a      (a[0]),
        .req0_b      (b[0]),
        .req1_valid  (v[1]),
        .req1_ready  (req1_ready),
        .req1_aluop  (op[1]),
        .req1_funct7 (f7[1]),
        .req1_funct3 (f3[1]),
        .req1_a      (a[1]),
        .req1_b      (b[1]),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_ready  (resp_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        for (int r = 0; r < 2; r++) begin
            op[r] = 2'($urandom_range(0, 3));
            f7[r] = 1'($urandom_range(0, 1));
            f3[r] = 3'($urandom_range(0, 7));
            a[r]  = $urandom;
            b[r]  = $urandom;
        end
    endtask

    task automatic set_fields(input int r, input logic [1:0] o, input logic s7,
                              input logic [2:0] s3, input logic [31:0] x, input logic [31:0] y);
        op[r] = o; f7[r] = s7; f3[r] = s3; a[r] = x; b[r] = y;
    endtask

    // One complete op: accept, EXEC, RESP held 'hold' extra cycles, release
    task automatic run_op(input logic v0i, input logic v1i, input int hold);
        int g;
        logic [3:0]  ec;
        logic [31:0] ea, eb, er;
        v[0] = v0i; v[1] = v1i; resp_ready = 1'b0;
        g  = (v0i && v1i) ? ((model_last == 1) ? 0 : 1) : (v0i ? 0 : 1);
        ec = model_ctrl(op[g], f7[g], f3[g]);
        ea = a[g]; eb = b[g];
        er = alu_fn(ec, ea, eb);
        #1;
        chk("accept_ready0", 32'(req0_ready), 32'(g == 0));
        chk("accept_ready1", 32'(req1_ready), 32'(g == 1));
        model_last = g;
        @(posedge clk); #1;
        // Disturb both requesters after the accept; must not affect the op
        for (int r = 0; r < 2; r++) begin
            a[r] = a[r] + 32'd94; b[r] = ~b[r]; f7[r] = ~f7[r]; op[r] = op[r] + 2'd1;
        end
        #1;
        chk("exec_ctrl", 32'(alu_ctrl), 32'(ec));
        chk("exec_a", alu_a, ea);
        chk("exec_b", alu_b, eb);
        chk("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("exec_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_result", resp_result, er);
            chk("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("hold_alu_ctrl", 32'(alu_ctrl), 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_id", 32'(resp_id), 32'(g));
        chk("resp_result", resp_result, er);
        chk("resp_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
        v[0] = 1'b0; v[1] = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("released", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        // Reset with both requesters asking: no ready while rst is high
        rand_fields();
        v[0] = 1'b1; v[1] = 1'b1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        rst = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
        model_last = 1;
        @(posedge clk); #1;

        // Both valid continuously: grants 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            rand_fields();
            run_op(1'b1, 1'b1, 0);
        end

        // Single requester 0: R-type sub 7-3
        rand_fields();
        set_fields(0, 2'b10, 1'b1, 3'b000, 32'd7, 32'd3);
        run_op(1'b1, 1'b0, 0);

        // Decode sweep
        rand_fields(); set_fields(0, 2'b11, 1'b1, 3'b000, 32'd10, 32'd4); run_op(1'b1, 1'b0, 0);
        rand_fields(); set_fields(1, 2'b11, 1'b1, 3'b101, 32'hF000_0000, 32'd4); run_op(1'b0, 1'b1, 0);
        rand_fields(); set_fields(0, 2'b11, 1'b0, 3'b101, 32'hF000_0000, 32'd4); run_op(1'b1, 1'b0, 0);
        rand_fields(); set_fields(1, 2'b10, 1'b0, 3'b110, 32'h0F0F_1234, 32'h00FF_00FF); run_op(1'b0, 1'b1, 0);
        rand_fields(); set_fields(0, 2'b01, 1'b0, 3'b111, 32'd5, 32'd9); run_op(1'b1, 1'b0, 0);
        rand_fields(); set_fields(1, 2'b00, 1'b1, 3'b101, 32'd20, 32'd22); run_op(1'b0, 1'b1, 0);

        // Backpressure for 5 cycles
        rand_fields();
        run_op(1'b0, 1'b1, 5);

        // Operand change on req1 after accept: a 5 -> 99 must not be used
        rand_fields();
        set_fields(1, 2'b00, 1'b0, 3'b000, 32'd5, 32'd10);
        run_op(1'b0, 1'b1, 1);

        // Idle with nothing requested produces nothing
        repeat (2) @(posedge clk);
        #1;
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_alu_ctrl", 32'(alu_ctrl), 32'd0);

        // Reset during EXEC aborts the op
        rand_fields();
        v[0] = 1'b1; v[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; v[0] = 1'b0;
        model_last = 1;
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_result", resp_result, 32'd0);
        chk("abort_alu_ctrl", 32'(alu_ctrl), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        rand_fields();
        run_op(1'b1, 1'b1, 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            int pat;
            pat = int'($urandom_range(1, 3));
            rand_fields();
            run_op(pat[0], pat[1], int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
